ysyx_lsu: RTL and testbench

- Multi-cycle load/store unit directly downstream of the execute stage.
- Captures an effective address, store data and access type from execute, then runs one valid/ready transaction on the data-memory port.
- Returns the aligned, sign- or zero-extended load result (or a store completion) to writeback through a valid/ready handshake.
- Replaces the combinational memory access currently stubbed out of execute.

---
 rtl/ysyx_lsu_if.sv | 51 +++++
 rtl/ysyx_lsu.sv | 190 +++++++++++++++++++
 tb/tb_ysyx_lsu.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_lsu_if.sv
// Bundle of the three LSU handshakes: execute request, data-memory port,
// writeback result. The LSU uses the slave view, its environment the master.
//
// Handshake rule for every valid/ready pair below: a transfer happens on a
// rising clock edge where both valid and ready are high; once valid is raised
// the sender keeps valid and its payload stable until that edge. The memory
// response (mem_rsp_valid) has no ready: it is a single-cycle pulse that is
// always taken.
interface ysyx_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [2:0]        in_rd_sel;
  logic [1:0]        in_wr_sel;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rdata;
  logic              out_err;

  modport slave (
    input  in_valid, in_addr, in_wdata, in_rd_sel, in_wr_sel,
    output in_ready,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output out_valid, out_rdata, out_err,
    input  out_ready
  );

  modport master (
    output in_valid, in_addr, in_wdata, in_rd_sel, in_wr_sel,
    input  in_ready,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  out_valid, out_rdata, out_err,
    output out_ready
  );
endinterface

// File: rtl/ysyx_lsu.sv
// Multi-cycle load/store unit: takes one access from execute, runs a single
// request/response on the data-memory port and hands the extended load data
// (or a store completion / error) to writeback. One access in flight at a time.
module ysyx_lsu #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  ysyx_lsu_if.slave        bus,
  output logic [1:0]       dbg_state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_e;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Last WAIT cycle: DONE then lands exactly TIMEOUT cycles after WAIT entry.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [2:0]        rd_sel_q, rd_sel_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wen_q, mem_wen_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              acc_load, acc_store, acc_half, acc_word, acc_mis, acc_ill;
  logic [3:0]        acc_mask;
  logic [DATA_W-1:0] acc_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;

  // Classify the incoming request and build its byte lanes.
  always_comb begin
    acc_load  = (bus.in_rd_sel >= 3'd1) && (bus.in_rd_sel <= 3'd5);
    acc_store = (bus.in_wr_sel != 2'd0);
    acc_half  = (bus.in_rd_sel == 3'd3) || (bus.in_rd_sel == 3'd4) || (bus.in_wr_sel == 2'd2);
    acc_word  = (bus.in_rd_sel == 3'd5) || (bus.in_wr_sel == 2'd3);
    acc_ill   = acc_load && acc_store;
    acc_mis   = (acc_half && bus.in_addr[0]) || (acc_word && (bus.in_addr[1:0] != 2'b00));
    acc_mask  = 4'h0;
    acc_wdata = '0;
    case (bus.in_wr_sel)
      2'd1: begin
        acc_mask  = 4'b0001 << bus.in_addr[1:0];
        acc_wdata = {4{bus.in_wdata[7:0]}};
      end
      2'd2: begin
        acc_mask  = 4'b0011 << bus.in_addr[1:0];
        acc_wdata = {2{bus.in_wdata[15:0]}};
      end
      2'd3: begin
        acc_mask  = 4'hF;
        acc_wdata = bus.in_wdata;
      end
      default: begin
        acc_mask  = 4'h0;
        acc_wdata = '0;
      end
    endcase
  end

  // Pick the addressed byte/half of the response and extend it for the load type.
  always_comb begin
    ld_byte = bus.mem_rdata[7:0];
    case (off_q)
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      2'd3:    ld_byte = bus.mem_rdata[31:24];
      default: ld_byte = bus.mem_rdata[7:0];
    endcase
    ld_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (rd_sel_q)
      3'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd2:    ld_data = {24'b0, ld_byte};
      3'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {16'b0, ld_half};
      3'd5:    ld_data = bus.mem_rdata;
      default: ld_data = '0;
    endcase
  end

  // Next-state and datapath updates for the IDLE/REQ/WAIT/DONE sequence.
  always_comb begin
    state_d     = state_q;
    rd_sel_d    = rd_sel_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = mem_wen_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          rd_sel_d    = bus.in_rd_sel;
          off_d       = bus.in_addr[1:0];
          cnt_d       = '0;
          rdata_d     = '0;
          err_d       = 1'b0;
          mem_addr_d  = '0;
          mem_wen_d   = 1'b0;
          mem_wdata_d = '0;
          mem_wmask_d = 4'h0;
          if (acc_ill || acc_mis) begin
            // Rejected accesses never touch the bus.
            state_d = DONE;
            err_d   = 1'b1;
          end else if (!acc_load && !acc_store) begin
            state_d = DONE;
          end else begin
            state_d     = REQ;
            mem_addr_d  = {bus.in_addr[ADDR_W-1:2], 2'b00};
            mem_wen_d   = acc_store;
            mem_wdata_d = acc_wdata;
            mem_wmask_d = acc_mask;
          end
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response on the final cycle beats the timeout.
        if (bus.mem_rsp_valid) begin
          state_d = DONE;
          rdata_d = ld_data;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_sel_q    <= 3'd0;
      off_q       <= 2'd0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= 4'h0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_sel_q    <= rd_sel_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wmask     = mem_wmask_q;
  assign bus.out_valid     = (state_q == DONE);
  assign bus.out_rdata     = rdata_q;
  assign bus.out_err       = err_q;
  assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_ysyx_lsu.sv
// Testbench for ysyx_lsu: a table of single accesses against a zero-wait
// memory, then hand-written sequences for stalls, timeouts, reset and
// writeback back-pressure.
module tb_ysyx_lsu;
  localparam int TIMEOUT = 255;
  localparam int NV = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  ysyx_lsu_if bus ();

  ysyx_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // scoreboard: {err, rdata} expected at each writeback handoff
  int          n_chk = 0;
  int          n_pass = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bus_acc;
    logic [31:0] e_addr;
    logic        e_wen;
    logic [31:0] e_wdata;
    logic [3:0]  e_mask;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[NV];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic sb_pop(input string name);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: result with no expected entry, got rdata 0x%08h err %b",
               name, bus.out_rdata, bus.out_err);
    end else begin
      e = exp_q.pop_front();
      check32({name, "_rdata"}, bus.out_rdata, e[31:0]);
      check1({name, "_err"}, bus.out_err, e[32]);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] rd, input logic [1:0] wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.in_valid  = 1'b1;
    bus.in_rd_sel = rd;
    bus.in_wr_sel = wr;
    bus.in_addr   = addr;
    bus.in_wdata  = wdata;
  endtask

  // One access against a zero-wait memory with cycle-exact latency checks.
  task automatic run_vec(input vec_t v, input string tag);
    check1({tag, "_in_ready"}, bus.in_ready, 1'b1);
    bus.mem_req_ready = 1'b1;
    bus.mem_rdata     = v.rdata;
    drive_req(v.rd, v.wr, v.addr, v.wdata);
    exp_q.push_back({v.e_err, v.e_rdata});
    tick();  // cycle 1
    bus.in_valid = 1'b0;
    if (v.bus_acc) begin
      check1({tag, "_req_valid"}, bus.mem_req_valid, 1'b1);
      check32({tag, "_addr"}, bus.mem_addr, v.e_addr);
      check1({tag, "_wen"}, bus.mem_wen, v.e_wen);
      check32({tag, "_wdata"}, bus.mem_wdata, v.e_wdata);
      check32({tag, "_wmask"}, {28'b0, bus.mem_wmask}, {28'b0, v.e_mask});
      check1({tag, "_early_out"}, bus.out_valid, 1'b0);
      tick();  // cycle 2: WAIT
      check1({tag, "_req_drop"}, bus.mem_req_valid, 1'b0);
      bus.mem_rsp_valid = 1'b1;
      tick();  // cycle 3
      bus.mem_rsp_valid = 1'b0;
    end else begin
      check1({tag, "_no_req"}, bus.mem_req_valid, 1'b0);
    end
    check1({tag, "_out_valid"}, bus.out_valid, 1'b1);
    sb_pop(tag);
    tick();  // handoff with out_ready high
    check1({tag, "_back_idle"}, bus.in_ready, 1'b1);
    check1({tag, "_out_drop"}, bus.out_valid, 1'b0);
  endtask

  task automatic seq_sb_stall();
    bus.mem_req_ready = 1'b0;
    drive_req(3'd0, 2'd1, 32'h8000_0001, 32'h1234_56AB);
    exp_q.push_back({1'b0, 32'h0});
    tick();  // cycle 1: REQ, memory stalls
    bus.in_valid      = 1'b0;
    bus.mem_rsp_valid = 1'b1;  // stray response outside WAIT
    bus.mem_rdata     = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      check1("stall_req_valid", bus.mem_req_valid, 1'b1);
      check32("stall_addr", bus.mem_addr, 32'h8000_0000);
      check32("stall_wdata", bus.mem_wdata, 32'hABAB_ABAB);
      check32("stall_wmask", {28'b0, bus.mem_wmask}, 32'h2);
      check1("stall_wen", bus.mem_wen, 1'b1);
      tick();
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    check1("stall_req_last", bus.mem_req_valid, 1'b1);
    tick();  // WAIT
    check1("stall_wait_req", bus.mem_req_valid, 1'b0);
    check1("stall_wait_out", bus.out_valid, 1'b0);
    bus.mem_rsp_valid = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
    check1("stall_out_valid", bus.out_valid, 1'b1);
    sb_pop("stall");
    tick();
    check1("stall_out_drop", bus.out_valid, 1'b0);
  endtask

  task automatic seq_timeout(input bit late_rsp);
    logic early;
    bus.mem_req_ready = 1'b1;
    bus.mem_rdata     = 32'h0BAD_F00D;
    drive_req(3'd5, 2'd0, 32'h8000_0020, 32'h0);
    if (late_rsp) exp_q.push_back({1'b0, 32'h0BAD_F00D});
    else          exp_q.push_back({1'b1, 32'h0});
    tick();  // REQ
    bus.in_valid = 1'b0;
    tick();  // first WAIT cycle
    early = 1'b0;
    for (int c = 0; c < TIMEOUT - 1; c++) begin
      if (bus.out_valid) early = 1'b1;
      tick();
    end
    // Last WAIT cycle.
    check1("tmo_no_early_out", early | bus.out_valid, 1'b0);
    if (late_rsp) bus.mem_rsp_valid = 1'b1;
    tick();  // TIMEOUT cycles after WAIT entry
    bus.mem_rsp_valid = 1'b0;
    check1("tmo_out_valid", bus.out_valid, 1'b1);
    sb_pop(late_rsp ? "tmo_rsp" : "tmo");
    tick();
    check1("tmo_out_drop", bus.out_valid, 1'b0);
  endtask

  task automatic seq_reset_hold();
    bus.mem_req_ready = 1'b1;
    drive_req(3'd5, 2'd0, 32'h8000_0040, 32'h0);
    tick();  // REQ
    bus.in_valid = 1'b0;
    tick();  // WAIT
    check32("rst_pre_state", {30'b0, dbg_state}, 32'd2);
    rst_n = 1'b0;
    tick();
    check1("rst_in_ready", bus.in_ready, 1'b1);
    check1("rst_req_valid", bus.mem_req_valid, 1'b0);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check32("rst_wmask", {28'b0, bus.mem_wmask}, 32'h0);
    rst_n = 1'b1;
    tick();
    check1("rst_no_stale_out", bus.out_valid, 1'b0);
    // Fresh SW after the aborted load.
    drive_req(3'd0, 2'd3, 32'h8000_0010, 32'hCAFE_F00D);
    exp_q.push_back({1'b0, 32'h0});
    tick();
    bus.in_valid = 1'b0;
    check1("sw_req_valid", bus.mem_req_valid, 1'b1);
    check32("sw_addr", bus.mem_addr, 32'h8000_0010);
    check32("sw_wmask", {28'b0, bus.mem_wmask}, 32'hF);
    check32("sw_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    check1("sw_wen", bus.mem_wen, 1'b1);
    tick();
    bus.mem_rsp_valid = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
    check1("sw_out_valid", bus.out_valid, 1'b1);
    sb_pop("sw");
    tick();
    // LB held in DONE by writeback back-pressure for 5 cycles.
    bus.mem_rdata = 32'h80FF_1234;
    drive_req(3'd1, 2'd0, 32'h8000_0003, 32'h0);
    exp_q.push_back({1'b0, 32'hFFFF_FF80});
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.mem_rsp_valid = 1'b1;
    bus.out_ready     = 1'b0;
    tick();  // DONE
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h7F7F_7F7F;
    drive_req(3'd0, 2'd0, 32'h0, 32'h0);  // no-op waiting behind the held result
    for (int c = 0; c < 5; c++) begin
      check1("hold_out_valid", bus.out_valid, 1'b1);
      check32("hold_out_rdata", bus.out_rdata, 32'hFFFF_FF80);
      check1("hold_in_ready", bus.in_ready, 1'b0);
      tick();
    end
    bus.out_ready = 1'b1;
    check1("hold_in_ready_handoff", bus.in_ready, 1'b0);
    sb_pop("hold");
    tick();  // IDLE: the waiting no-op is only taken now
    check1("hold_idle_in_ready", bus.in_ready, 1'b1);
    check1("hold_idle_out", bus.out_valid, 1'b0);
    exp_q.push_back({1'b0, 32'h0});
    tick();
    bus.in_valid = 1'b0;
    check1("noop_out_valid", bus.out_valid, 1'b1);
    sb_pop("noop");
    tick();
    check1("noop_out_drop", bus.out_valid, 1'b0);
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_addr       = 32'h0;
    bus.in_wdata      = 32'h0;
    bus.in_rd_sel     = 3'd0;
    bus.in_wr_sel     = 2'd0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;
    bus.out_ready     = 1'b1;

    //          rd    wr    addr          wdata         rdata        bus   e_addr        wen   e_wdata       mask   e_rdata       err
    vecs[0]  = '{3'd1, 2'd0, 32'h8000_0003, 32'h0,        32'h80FF_1234, 1'b1, 32'h8000_0000, 1'b0, 32'h0,        4'h0, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{3'd4, 2'd0, 32'h8000_0002, 32'h0,        32'hBEEF_0000, 1'b1, 32'h8000_0000, 1'b0, 32'h0,        4'h0, 32'h0000_BEEF, 1'b0};
    vecs[2]  = '{3'd3, 2'd0, 32'h8000_0002, 32'h0,        32'hBEEF_0000, 1'b1, 32'h8000_0000, 1'b0, 32'h0,        4'h0, 32'hFFFF_BEEF, 1'b0};
    vecs[3]  = '{3'd2, 2'd0, 32'h8000_0001, 32'h0,        32'h1234_5678, 1'b1, 32'h8000_0000, 1'b0, 32'h0,        4'h0, 32'h0000_0056, 1'b0};
    vecs[4]  = '{3'd5, 2'd0, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 1'b1, 32'h8000_0004, 1'b0, 32'h0,        4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[5]  = '{3'd3, 2'd0, 32'h8000_0000, 32'h0,        32'h0001_8001, 1'b1, 32'h8000_0000, 1'b0, 32'h0,        4'h0, 32'hFFFF_8001, 1'b0};
    vecs[6]  = '{3'd0, 2'd2, 32'h8000_0002, 32'h1234_ABCD, 32'h5555_5555, 1'b1, 32'h8000_0000, 1'b1, 32'hABCD_ABCD, 4'hC, 32'h0,        1'b0};
    vecs[7]  = '{3'd0, 2'd3, 32'h8000_0010, 32'hCAFE_F00D, 32'h5555_5555, 1'b1, 32'h8000_0010, 1'b1, 32'hCAFE_F00D, 4'hF, 32'h0,        1'b0};
    vecs[8]  = '{3'd0, 2'd1, 32'h8000_0003, 32'h0000_00EE, 32'h5555_5555, 1'b1, 32'h8000_0000, 1'b1, 32'hEEEE_EEEE, 4'h8, 32'h0,        1'b0};
    vecs[9]  = '{3'd5, 2'd0, 32'h8000_0002, 32'h0,        32'h1111_1111, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[10] = '{3'd0, 2'd2, 32'h8000_0001, 32'h0,        32'h1111_1111, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[11] = '{3'd1, 2'd1, 32'h8000_0000, 32'h0,        32'h1111_1111, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[12] = '{3'd0, 2'd0, 32'h8000_0000, 32'h0,        32'h1111_1111, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[13] = '{3'd6, 2'd0, 32'h8000_0000, 32'h0,        32'h1111_1111, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[14] = '{3'd7, 2'd3, 32'h8000_0008, 32'h1122_3344, 32'h5555_5555, 1'b1, 32'h8000_0008, 1'b1, 32'h1122_3344, 4'hF, 32'h0,        1'b0};
    vecs[15] = '{3'd3, 2'd0, 32'h8000_0003, 32'h0,        32'h1111_1111, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[16] = '{3'd2, 2'd0, 32'h8000_0003, 32'h0,        32'h80FF_1234, 1'b1, 32'h8000_0000, 1'b0, 32'h0,        4'h0, 32'h0000_0080, 1'b0};
    vecs[17] = '{3'd0, 2'd1, 32'h8000_0004, 32'hA5A5_A53C, 32'h5555_5555, 1'b1, 32'h8000_0004, 1'b1, 32'h3C3C_3C3C, 4'h1, 32'h0,        1'b0};
    vecs[18] = '{3'd5, 2'd1, 32'h8000_0000, 32'h0,        32'h1111_1111, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[19] = '{3'd6, 2'd2, 32'h8000_0001, 32'h0,        32'h1111_1111, 1'b0, 32'h0,        1'b0, 32'h0,        4'h0, 32'h0,        1'b1};

    repeat (3) tick();
    check1("reset_in_ready", bus.in_ready, 1'b1);
    check1("reset_req_valid", bus.mem_req_valid, 1'b0);
    check1("reset_wen", bus.mem_wen, 1'b0);
    check32("reset_addr", bus.mem_addr, 32'h0);
    check32("reset_wdata", bus.mem_wdata, 32'h0);
    check32("reset_wmask", {28'b0, bus.mem_wmask}, 32'h0);
    check1("reset_out_valid", bus.out_valid, 1'b0);
    check32("reset_out_rdata", bus.out_rdata, 32'h0);
    check1("reset_out_err", bus.out_err, 1'b0);
    check32("reset_state", {30'b0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    seq_sb_stall();
    seq_timeout(1'b0);
    seq_timeout(1'b1);
    seq_reset_hold();

    check32("sb_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
